load_size_ctrl: RTL
===================

# load_size_ctrl

Sequential load-path unit for the multicycle MIPS datapath, the read-side counterpart of the store-size merge logic. On a load request it drives a word read to memory, waits a fixed memory latency, captures the returned word into an internal MDR, and presents the requested word, halfword or byte, zero- or sign-extended to 32 bits. It sits between the control unit's load states and the memory, and feeds the register-file write-data mux.

## Interface
- MEM_LATENCY, 2: cycles `mem_rd` is held before `mem_rdata` is sampled; legal range 1..15.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; returns the unit to IDLE.
- start  input  1  load request; sampled only in IDLE or DONE.
- LScontrol  input  2  01 lw, 11 lh, 10 lb; 00 illegal.
- LSsigned  input  1  1 = sign-extend lh/lb, 0 = zero-extend; ignored for lw.
- addr  input  32  word address of the load.
- mem_rdata  input  32  memory read data.
- mem_addr  output  32  address to memory; registered.
- mem_rd  output  1  memory read strobe.
- MDR_out  output  32  raw captured memory word.
- LS_out  output  32  sized and extended load result.
- busy  output  1  high while a read is in progress (WAIT).
- done  output  1  one-cycle pulse, LS_out newly valid.
- err  output  1  one-cycle pulse, illegal LScontrol on accepted start.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE/DONE + start + legal LScontrol: latch addr into mem_addr, latch LScontrol/LSsigned, load counter with MEM_LATENCY, go to WAIT.
- IDLE/DONE + start + LScontrol=00: err=1 next cycle, no memory access, MDR_out/LS_out/mem_addr unchanged; go to IDLE.
- IDLE/DONE without start: go to IDLE.
- WAIT: mem_rd=1, busy=1, mem_addr stable; counter decrements each cycle. On the edge ending the cycle in which counter==1, capture mem_rdata into MDR, update LS_out, go to DONE.
- DONE: done=1 for exactly one cycle; mem_rd=0, busy=0.
- start in WAIT is ignored (not queued).
- Sizing uses the low lanes of the captured word, matching store-side lane use: lw: LS_out=MDR; lh: LS_out={16{s&MDR[15]},MDR[15:0]}; lb: LS_out={24{s&MDR[7]},MDR[7:0]}, where s=latched LSsigned.
- LS_out and MDR_out hold their value until the next successful capture.

## Timing
- Reset values: state IDLE, mem_addr=0, mem_rd=0, MDR_out=0, LS_out=0, busy=0, done=0, err=0, counter=0.
- mem_rd, busy, done and err are decoded from registered state only (no combinational path from start).
- Start sampled at edge k: WAIT occupies cycles k+1..k+MEM_LATENCY; capture at the end of cycle k+MEM_LATENCY; done high in cycle k+MEM_LATENCY+1.
- Start-to-done latency: MEM_LATENCY+1 cycles; back-to-back throughput: one load per MEM_LATENCY+1 cycles (start accepted in the DONE cycle).
- mem_rdata is sampled only at the capture edge; all other values are ignored.
- Reset asserted mid-WAIT: mem_rd and busy drop immediately (asynchronously), the load is discarded, and done does not pulse. Outputs take reset values.
- Reset asserted in DONE: done drops immediately.

## Test plan
- Reset: assert reset mid-sim -> all outputs 0, state IDLE; deassert, idle 5 cycles -> mem_rd never asserted.
- lw, MEM_LATENCY=2: start, addr=0x0000_0040, mem_rdata=0xDEAD_BEEF at capture -> mem_rd high 2 cycles with mem_addr=0x40, done in cycle 3, LS_out=MDR_out=0xDEADBEEF.
- lh/lb extension: mem_rdata=0x1234_8086 -> lh unsigned 0x0000_8086, lh signed 0xFFFF_8086, lb unsigned 0x0000_0086, lb signed 0xFFFF_FF86.
- Back-to-back with start held during WAIT: second start in DONE is accepted immediately, and starts during WAIT are ignored -> exactly two mem_rd bursts and two done pulses, second LS_out correct.
- Illegal op: start with LScontrol=00 -> err pulse 1 cycle, mem_rd stays 0, LS_out unchanged from prior 0xDEADBEEF.
- Reset mid-WAIT (cycle k+1) -> mem_rd drops same cycle, no done, LS_out=0; subsequent lw completes normally.

Source files
------------

// File: rtl/load_size_ctrl.sv
// load_size_ctrl
// Load-path unit for the multicycle MIPS datapath. On an accepted load request
// it holds a word read to memory for MEM_LATENCY cycles, captures the returned
// word into the MDR, and presents the word, halfword or byte (zero- or
// sign-extended) on ls_out_o. It is the read-side partner of the store-size
// merge logic and uses the same low byte lanes.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_i       asynchronous, active-high reset
//   start_i       load request, honoured in IDLE or DONE only
//   ls_control_i  01 lw, 11 lh, 10 lb, 00 illegal
//   ls_signed_i   1 = sign-extend lh/lb, 0 = zero-extend
//   addr_i        word address of the load
//   mem_rdata_i   memory read data
//   mem_addr_o    registered address to memory
//   mem_rd_o      memory read strobe (WAIT)
//   mdr_out_o     raw captured memory word
//   ls_out_o      sized and extended load result
//   busy_o        read in progress (WAIT)
//   done_o        one-cycle pulse, ls_out_o newly valid
//   err_o         one-cycle pulse, illegal ls_control_i on a start
//
// state | meaning
// IDLE  | no load in progress
// WAIT  | read strobe held, counting down memory latency
// DONE  | result valid, done pulse; a new start may be accepted here
module load_size_ctrl #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  ls_control_i,
    input  logic        ls_signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic [31:0] mdr_out_o,
    output logic [31:0] ls_out_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_LH = 2'b11;
    localparam logic [1:0] OP_LB = 2'b10;
    localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] ls_q, ls_d;
    logic [1:0]  op_q, op_d;
    logic        sgn_q, sgn_d;
    logic        err_q, err_d;

    // Sizing always reads the low lanes of the word, mirroring store-side lanes.
    function automatic logic [31:0] size_word(input logic [1:0] op,
                                              input logic s,
                                              input logic [31:0] w);
        logic [31:0] r;
        r = w;
        case (op)
            OP_LH:   r = {{16{s & w[15]}}, w[15:0]};
            OP_LB:   r = {{24{s & w[7]}}, w[7:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            mdr_q   <= '0;
            ls_q    <= '0;
            op_q    <= OP_LW;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mdr_q   <= mdr_d;
            ls_q    <= ls_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        mdr_d   = mdr_q;
        ls_d    = ls_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    if (ls_control_i != 2'b00) begin
                        addr_d  = addr_i;
                        op_d    = ls_control_i;
                        sgn_d   = ls_signed_i;
                        cnt_d   = LAT;
                        state_d = S_WAIT;
                    end else begin
                        // Illegal size: flag it, touch nothing else.
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    mdr_d   = mem_rdata_i;
                    ls_d    = size_word(op_q, sgn_q, mem_rdata_i);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes come from registered state only, so reset clears them at once.
    assign mem_rd_o   = (state_q == S_WAIT);
    assign busy_o     = (state_q == S_WAIT);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign mem_addr_o = addr_q;
    assign mdr_out_o  = mdr_q;
    assign ls_out_o   = ls_q;

endmodule
